// File: rtl/flitzip_pkg.sv
// Shared constants and types for the FlitZip compressor arbiter.
// State encoding for the wormhole lock FSM.
package flitzip_pkg;

  localparam int FLIT_W = 128;
  localparam int EN_W   = 3;

  typedef enum logic {
    IDLE,
    LOCKED
  } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotate-priority arbiter.
// Grants the first request at or after ptr, wrapping at N.
module rr_arbiter #(
  parameter  int N     = 4,
  localparam int PTR_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [PTR_W-1:0] idx,
  output logic             any
);

  logic [PTR_W:0] s;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    s     = '0;
    for (int k = 0; k < N; k++) begin
      s = {1'b0, ptr} + (PTR_W+1)'(k);
      if (s >= (PTR_W+1)'(N))
        s = s - (PTR_W+1)'(N);
      if (!any && req[s[PTR_W-1:0]]) begin
        any                   = 1'b1;
        idx                   = s[PTR_W-1:0];
        grant[s[PTR_W-1:0]]   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/flit_comp_arbiter.sv
// Shares one flit compressor between N_PORTS wormhole input ports.
// Head flits arbitrate round-robin; the winner holds the lock to its tail.
module flit_comp_arbiter #(
  parameter  int N_PORTS = 4,
  parameter  int FLIT_W  = flitzip_pkg::FLIT_W,
  parameter  int EN_W    = flitzip_pkg::EN_W,
  localparam int PTR_W   = $clog2(N_PORTS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_PORTS-1:0]        req_valid,
  input  logic [N_PORTS*FLIT_W-1:0] req_flit,
  input  logic [N_PORTS-1:0]        req_head,
  input  logic [N_PORTS-1:0]        req_tail,
  output logic [N_PORTS-1:0]        req_ready,
  output logic [FLIT_W-1:0]         comp_data,
  output logic                      comp_is_head,
  input  logic [EN_W-1:0]           comp_en,
  input  logic [FLIT_W-1:0]         comp_flit,
  output logic                      out_valid,
  output logic [FLIT_W-1:0]         out_flit,
  output logic [EN_W-1:0]           out_en,
  output logic [PTR_W-1:0]          out_port,
  output logic                      out_tail,
  input  logic                      out_ready
);

  import flitzip_pkg::*;

  state_t             state_q;
  state_t             state_d;
  logic [PTR_W-1:0]   rr_ptr;
  logic [PTR_W-1:0]   owner;
  logic [PTR_W-1:0]   grant_idx;
  logic [PTR_W-1:0]   sel_idx;
  logic [PTR_W-1:0]   ptr_inc;
  logic [N_PORTS-1:0] cand;
  logic [N_PORTS-1:0] grant_oh;
  logic               any_cand;
  logic               adv;
  logic               sel_vld;
  logic               acc;

  assign cand = req_valid & req_head;
  assign adv  = !out_valid | out_ready;

  rr_arbiter #(.N(N_PORTS)) u_arb (
    .req   (cand),
    .ptr   (rr_ptr),
    .grant (grant_oh),
    .idx   (grant_idx),
    .any   (any_cand)
  );

  // A head seen while locked is passed through as a body flit.
  always_comb begin
    state_d      = state_q;
    sel_idx      = owner;
    sel_vld      = 1'b0;
    comp_is_head = 1'b0;
    unique case (state_q)
      IDLE: begin
        sel_idx      = grant_idx;
        sel_vld      = any_cand;
        comp_is_head = any_cand;
        if (any_cand && adv && !req_tail[grant_idx])
          state_d = LOCKED;
      end
      LOCKED: begin
        sel_idx = owner;
        sel_vld = req_valid[owner];
        if (req_valid[owner] && adv && req_tail[owner])
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign acc = sel_vld & adv;

  always_comb begin
    req_ready = '0;
    if (acc && !rst)
      req_ready[sel_idx] = 1'b1;
  end

  assign comp_data = sel_vld ?
    req_flit[sel_idx*FLIT_W +: FLIT_W] : '0;

  assign ptr_inc = (sel_idx == PTR_W'(N_PORTS-1)) ?
    '0 : sel_idx + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      rr_ptr    <= '0;
      owner     <= '0;
      out_valid <= 1'b0;
      out_flit  <= '0;
      out_en    <= '0;
      out_port  <= '0;
      out_tail  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (acc && state_q == IDLE) begin
        rr_ptr <= ptr_inc;
        owner  <= sel_idx;
      end
      if (acc) begin
        out_valid <= 1'b1;
        out_flit  <= comp_flit;
        out_en    <= comp_en;
        out_port  <= sel_idx;
        out_tail  <= req_tail[sel_idx];
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_flit_comp_arbiter.sv
// Randomized self-checking bench for flit_comp_arbiter.
// A packet-level model predicts grants and output register contents.
module tb_flit_comp_arbiter;

  localparam int N = 4;
  localparam int W = 128;

  typedef struct {
    logic         h;
    logic         t;
    logic [W-1:0] d;
  } fd_t;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   vld, hd, tl;
  logic [W-1:0]   fl [N];
  logic [N*W-1:0] req_flit;
  logic [N-1:0]   req_ready;
  logic [W-1:0]   comp_data;
  logic           comp_is_head;
  logic [2:0]     comp_en;
  logic [W-1:0]   comp_flit;
  logic           out_valid;
  logic [W-1:0]   out_flit;
  logic [2:0]     out_en;
  logic [1:0]     out_port;
  logic           out_tail;
  logic           out_ready;

  int n_chk  = 0;
  int n_pass = 0;

  fd_t q [N][$];
  int  olog [$];

  bit           m_lock;
  int           m_own, m_ptr, m_port;
  bit           m_ov, m_tail;
  logic [W-1:0] m_flit;
  logic [2:0]   m_en;
  logic [N-1:0] acc;

  always #5 clk = ~clk;

  always_comb
    for (int p = 0; p < N; p++)
      req_flit[p*W +: W] = fl[p];

  function automatic logic [W-1:0] cmp_flit(logic [W-1:0] d);
    return {d[63:0], d[127:64]} ^ 128'h5A;
  endfunction

  function automatic logic [2:0] cmp_en(logic [W-1:0] d, logic h);
    return d[2:0] ^ {h, 2'b01};
  endfunction

  assign comp_flit = cmp_flit(comp_data);
  assign comp_en   = cmp_en(comp_data, comp_is_head);

  flit_comp_arbiter dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (vld),
    .req_flit     (req_flit),
    .req_head     (hd),
    .req_tail     (tl),
    .req_ready    (req_ready),
    .comp_data    (comp_data),
    .comp_is_head (comp_is_head),
    .comp_en      (comp_en),
    .comp_flit    (comp_flit),
    .out_valid    (out_valid),
    .out_flit     (out_flit),
    .out_en       (out_en),
    .out_port     (out_port),
    .out_tail     (out_tail),
    .out_ready    (out_ready)
  );

  task automatic chk(string tag, logic [W-1:0] obs,
                     logic [W-1:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", tag, obs, exp);
  endtask

  task automatic m_reset();
    m_lock = 0; m_own = 0; m_ptr = 0; m_port = 0;
    m_ov = 0; m_tail = 0; m_flit = '0; m_en = '0;
  endtask

  // One clock: check at negedge, advance model, return at posedge+1.
  task automatic tick();
    int sel;
    bit adv;
    logic [N-1:0] er;
    logic [W-1:0] ed;
    @(negedge clk);
    adv = !m_ov || out_ready;
    sel = -1;
    if (!m_lock) begin
      for (int k = 0; k < N; k++) begin
        int p = (m_ptr + k) % N;
        if (sel < 0 && vld[p] && hd[p]) sel = p;
      end
    end else if (vld[m_own]) sel = m_own;
    er = '0;
    if (!rst && adv && sel >= 0) er[sel] = 1'b1;
    ed = (sel >= 0) ? fl[sel] : '0;
    chk("req_ready", req_ready, er);
    chk("is_head", comp_is_head, !m_lock && sel >= 0);
    chk("comp_data", comp_data, ed);
    chk("out_valid", out_valid, m_ov);
    chk("out_flit", out_flit, m_flit);
    chk("out_en", out_en, m_en);
    chk("out_port", out_port, m_port);
    chk("out_tail", out_tail, m_tail);
    if (out_valid === 1'b1 && out_ready)
      olog.push_back(int'(out_port));
    acc = er;
    if (rst) m_reset();
    else if (er != '0) begin
      m_ov = 1; m_flit = cmp_flit(fl[sel]);
      m_en = cmp_en(fl[sel], !m_lock);
      m_port = sel; m_tail = tl[sel];
      if (!m_lock) begin
        m_ptr = (sel + 1) % N;
        if (!tl[sel]) begin m_lock = 1; m_own = sel; end
      end else if (tl[sel]) m_lock = 0;
    end else if (out_ready) m_ov = 0;
    @(posedge clk);
    #1;
  endtask

  task automatic present(bit rnd);
    if (rnd) out_ready = ($urandom_range(0, 3) != 0);
    for (int p = 0; p < N; p++) begin
      if (q[p].size() > 0 &&
          (!rnd || vld[p] || $urandom_range(0, 2) != 0)) begin
        vld[p] = 1; hd[p] = q[p][0].h;
        tl[p] = q[p][0].t; fl[p] = q[p][0].d;
      end else begin
        vld[p] = 0; hd[p] = 1'($urandom);
        tl[p] = 1'($urandom);
        fl[p] = {$urandom, $urandom, $urandom, $urandom};
      end
    end
  endtask

  task automatic pop_acc();
    for (int p = 0; p < N; p++)
      if (acc[p] && q[p].size() > 0) void'(q[p].pop_front());
  endtask

  task automatic run(int n, bit rnd);
    repeat (n) begin
      present(rnd);
      tick();
      pop_acc();
    end
  endtask

  task automatic add_pkt(int p, int len);
    for (int i = 0; i < len; i++) begin
      fd_t f;
      f.h = (i == 0);
      f.t = (i == len - 1);
      f.d = {$urandom, $urandom, $urandom, 24'(p), 8'(i)};
      q[p].push_back(f);
    end
  endtask

  initial begin
    int exp3 [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
    int exp2 [6] = '{0, 0, 0, 2, 2, 2};
    logic [2:0] ce;
    int guard, left;
    fd_t f;
    m_reset();
    rst = 1; out_ready = 1;
    vld = '1; hd = '1; tl = '0;
    for (int p = 0; p < N; p++)
      fl[p] = {$urandom, $urandom, $urandom, $urandom};
    @(posedge clk); #1;
    tick(); tick();
    rst = 0;

    add_pkt(0, 3); add_pkt(2, 3);
    olog.delete();
    run(8, 0);
    chk("t2_count", olog.size(), 6);
    for (int i = 0; i < 6 && i < olog.size(); i++)
      chk("t2_port", olog[i], exp2[i]);

    for (int r = 0; r < 2; r++)
      for (int p = 0; p < N; p++) add_pkt(p, 1);
    rst = 1; run(1, 0); rst = 0;
    olog.delete();
    run(10, 0);
    chk("t3_count", olog.size(), 8);
    for (int i = 0; i < 8 && i < olog.size(); i++)
      chk("t3_order", olog[i], exp3[i]);

    olog.delete();
    add_pkt(1, 4);
    run(2, 0);
    out_ready = 0; run(5, 0);
    out_ready = 1; run(5, 0);
    chk("t4_count", olog.size(), 4);
    foreach (olog[i]) chk("t4_port", olog[i], 1);

    f.h = 1; f.t = 1; f.d = 128'hFAC68915ACEF098F;
    q[3].push_back(f);
    present(0); #2;
    chk("t5_is_head", comp_is_head, 1'b1);
    ce = comp_en;
    tick(); pop_acc();
    #2 chk("t5_out_en", out_en, ce);

    add_pkt(1, 3);
    run(2, 0);
    add_pkt(3, 1);
    rst = 1; run(1, 0); rst = 0;
    q[1].delete();
    present(0); #2;
    chk("t6_grant", req_ready, 4'b1000);
    tick(); pop_acc();
    run(2, 0);

    for (int p = 0; p < N; p++)
      repeat (6) add_pkt(p, $urandom_range(1, 4));
    run(300, 1);
    out_ready = 1;
    guard = 0;
    left = 1;
    while (left > 0 && guard < 200) begin
      run(1, 0);
      guard++;
      left = 0;
      for (int p = 0; p < N; p++) left += q[p].size();
    end
    run(3, 0);
    chk("drained", left, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
